// File: rtl/gcd_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gcd_seq_pkg : shared state encoding and default ALU select codes     |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package gcd_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    CMP  = 3'd2,
    SUB  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [5:0] c_sel_sub_default  = 6'b000_101;
  localparam logic [5:0] c_sel_idle_default = 6'b000_000;

endpackage
`default_nettype wire

// File: rtl/edge_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | edge_sync : two-flop synchronizer plus rising-edge pulse detector    |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_level,
  output logic o_pulse
);

  logic s1_q, s2_q, s3_q;
  logic v1_q, v2_q;
  logic armed_q, armed_d;

  // A level already high when reset releases must not look like a rise:
  // arm only once the synchronized level has been seen low.
  always_comb begin
    armed_d = armed_q | (v2_q & ~s2_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      s1_q    <= i_level;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      v1_q    <= 1'b1;
      v2_q    <= v1_q;
      armed_q <= armed_d;
    end
  end

  assign o_pulse = s2_q & ~s3_q & armed_q;

endmodule
`default_nettype wire

// File: rtl/gcd_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gcd_seq : subtractive GCD sequencer driving an external shared ALU   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module gcd_seq
  import gcd_seq_pkg::*;
#(
  parameter int         WIDTH    = 12,
  parameter logic [5:0] SEL_SUB  = c_sel_sub_default,
  parameter logic [5:0] SEL_IDLE = c_sel_idle_default
) (
  input  logic             lcdclk,
  input  logic             resetn,
  input  logic             start_lvl,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [5:0]       alu_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_y,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] iter,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [WIDTH-1:0] c_zero = '0;
  localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic w_start_pls;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d, rb_q, rb_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [WIDTH-1:0] result_q, result_d, iter_q, iter_d;
  logic             sel_a_q, sel_a_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [5:0]       alu_sel_q, alu_sel_d;

  edge_sync u_edge_sync (
    .clk     (lcdclk),
    .rst_n   (resetn),
    .i_level (start_lvl),
    .o_pulse (w_start_pls)
  );

  always_comb begin
    state_d  = state_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    result_d = result_q;
    iter_d   = iter_q;
    sel_a_d  = sel_a_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (w_start_pls) state_d = LOAD;
      end
      LOAD: begin
        ra_d     = a_in;
        rb_d     = b_in;
        iter_d   = c_zero;
        err_d    = 1'b0;
        result_d = c_zero;
        if ((a_in == c_zero) && (b_in == c_zero)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (a_in == c_zero) begin
          result_d = b_in;
          state_d  = DONE;
        end else if (b_in == c_zero) begin
          result_d = a_in;
          state_d  = DONE;
        end else begin
          state_d = CMP;
        end
      end
      CMP: begin
        if (ra_q == rb_q) begin
          result_d = ra_q;
          state_d  = DONE;
        end else if (ra_q > rb_q) begin
          alu_a_d = ra_q;
          alu_b_d = rb_q;
          sel_a_d = 1'b1;
          state_d = SUB;
        end else begin
          alu_a_d = rb_q;
          alu_b_d = ra_q;
          sel_a_d = 1'b0;
          state_d = SUB;
        end
      end
      SUB: begin
        if (sel_a_q) ra_d = alu_y;
        else         rb_d = alu_y;
        iter_d  = iter_q + c_one;
        state_d = CMP;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status outputs are registered from the next state so they line up with it.
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    alu_sel_d = (state_d == SUB) ? SEL_SUB : SEL_IDLE;
  end

  always_ff @(posedge lcdclk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      ra_q      <= '0;
      rb_q      <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      result_q  <= '0;
      iter_q    <= '0;
      sel_a_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      alu_sel_q <= SEL_IDLE;
    end else begin
      state_q   <= state_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      result_q  <= result_d;
      iter_q    <= iter_d;
      sel_a_q   <= sel_a_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      alu_sel_q <= alu_sel_d;
    end
  end

  assign alu_sel = alu_sel_q;
  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;
  assign result  = result_q;
  assign iter    = iter_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule
`default_nettype wire

// File: doc/gcd_seq.md
GCD_SEQ -- requirements
Module: gcd_seq

Interface
REQ-001 The module SHALL have parameter WIDTH, default 12, which sets the operand, ALU and result width.
REQ-002 The module SHALL have parameter SEL_SUB, default 6'b000_101, which is the ALU select code for Y = A - B.
REQ-003 The module SHALL have parameter SEL_IDLE, default 6'b000_000, which is the ALU select code driven when no subtraction is requested.
REQ-004 Port lcdclk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-005 Port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port start_lvl, input, 1 bit: raw asynchronous level from a switch; a rising edge requests one GCD run.
REQ-007 Port a_in, input, WIDTH bits: operand A.
REQ-008 Port b_in, input, WIDTH bits: operand B.
REQ-009 Port alu_sel, output, 6 bits: select code to the shared ALU.
REQ-010 Port alu_a and port alu_b, output, WIDTH bits each: ALU operands.
REQ-011 Port alu_y, input, WIDTH bits: combinational ALU result.
REQ-012 Port result, output, WIDTH bits: the GCD, held until the next run loads operands.
REQ-013 Port iter, output, WIDTH bits: count of subtractions performed in the last run.
REQ-014 Port busy, output, 1 bit: high in every state except IDLE.
REQ-015 Port done, output, 1 bit: one-cycle completion pulse.
REQ-016 Port err, output, 1 bit: high when both operands were zero; held with result.

Function
REQ-017 start_lvl SHALL pass through two synchronizer flops plus one history flop, giving start_pls = s2 & ~s3; a rise first sampled at edge k SHALL assert start_pls during the cycle after edge k+1.
REQ-018 The FSM SHALL have exactly the states IDLE, LOAD, CMP, SUB and DONE.
REQ-019 In IDLE, start_pls SHALL cause a move to LOAD; otherwise the FSM SHALL stay in IDLE.
REQ-020 In LOAD, the FSM SHALL capture ra<=a_in, rb<=b_in and iter<=0, and clear err.
REQ-021 From LOAD, if both operands are zero: result<=0, err<=1, go to DONE.
REQ-022 From LOAD, if exactly one operand is zero: result<=the nonzero operand, go to DONE.
REQ-023 From LOAD, in all other cases, go to CMP.
REQ-024 In CMP, if ra==rb: result<=ra, go to DONE.
REQ-025 In CMP, if ra>rb: drive alu_a=ra, alu_b=rb, set the flag sel_a=1, go to SUB.
REQ-026 In CMP, otherwise: drive alu_a=rb, alu_b=ra, set sel_a=0, go to SUB.
REQ-027 In SUB, alu_sel SHALL equal SEL_SUB with the operands held.
REQ-028 In SUB, alu_y SHALL be written to ra if sel_a=1, else to rb.
REQ-029 In SUB, iter SHALL be incremented and the FSM SHALL return to CMP.
REQ-030 alu_sel SHALL equal SEL_IDLE in every state other than SUB.
REQ-031 alu_a and alu_b SHALL be registered outputs and SHALL hold their last value outside CMP/SUB.
REQ-032 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-033 Latency: with the start_pls cycle taken as cycle 0, done SHALL be high in cycle 2 for the zero-operand cases and in cycle 3+2*iter otherwise.
REQ-034 start_pls outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-035 The block SHALL compare unsigned and perform no wrap-around arithmetic: the subtrahend is always strictly smaller, and iter ≤ 2^WIDTH-2.

Reset
REQ-036 resetn low SHALL asynchronously force: state=IDLE; sync flops=0; ra, rb, alu_a, alu_b, result, iter=0; busy, done, err=0; alu_sel=SEL_IDLE.
REQ-037 Reset asserted mid-run SHALL abort the run with no done pulse.
REQ-038 After reset release, a start_lvl already held high SHALL NOT start a run; a fresh rising edge is required.

Structure
REQ-039 Package gcd_seq_pkg SHALL hold the state enumeration and the default SEL_SUB and SEL_IDLE constants.
REQ-040 Sub-module edge_sync SHALL implement the two-flop synchronizer plus rising-edge detector (clock, asynchronous reset, level in, pulse out).
REQ-041 The ALU SHALL remain external, instantiated beside this block in the top level.

Verification
REQ-042 The bench SHALL cover: a_in=12, b_in=18, start rise -> result=6, iter=2, done exactly once in cycle 7, err=0.
REQ-043 The bench SHALL cover: a_in=4095, b_in=1 -> result=1, iter=4094, done in cycle 8191.
REQ-044 The bench SHALL cover: a_in=0, b_in=7 -> result=7, iter=0, err=0, done in cycle 2; and a_in=0, b_in=0 -> result=0, err=1.
REQ-045 The bench SHALL cover: a second start_lvl rise while busy (a_in=12, b_in=18) -> a single done, result=6, no second run afterwards.
REQ-046 The bench SHALL cover: resetn pulsed low mid-run at iter=3 (a_in=100, b_in=1) -> immediate IDLE with all outputs 0 and no done; a following start with a_in=9, b_in=6 -> result=3, iter=2.
